// File: rtl/telem_rx_if.sv
// Byte-stream handshake from UART_rcv plus the decoded telemetry
// outputs of the packet receiver.
interface telem_rx_if;
    logic        rdy;
    logic [7:0]  rx_data;
    logic        clr_rdy;
    logic [11:0] batt;
    logic [11:0] curr;
    logic [11:0] torque;
    logic        vld;
    logic        frm_err;
    logic [7:0]  pkt_cnt;
    logic [7:0]  err_cnt;

    modport master (
        output rdy, rx_data,
        input  clr_rdy, batt, curr, torque,
        input  vld, frm_err, pkt_cnt, err_cnt
    );

    modport slave (
        input  rdy, rx_data,
        output clr_rdy, batt, curr, torque,
        output vld, frm_err, pkt_cnt, err_cnt
    );
endinterface

// File: rtl/telem_rx.sv
// Telemetry packet receiver: frames 8-byte AA 55 packets into an atomic
// battery/current/torque triple, with framing and stall error counting.
module telem_rx #(
    parameter int TMO_CYC = 100000
) (
    input logic       clk,
    input logic       rst_n,
    telem_rx_if.slave bus
);
    localparam int CW = $clog2(TMO_CYC) + 1;
    localparam logic [CW-1:0] TMO_M1 = CW'(TMO_CYC - 1);

    typedef enum logic [2:0] {
        SYNC1, SYNC2, B_HI, B_LO, C_HI, C_LO, T_HI, T_LO
    } state_t;

    state_t        state;
    logic [CW-1:0] tmo;
    logic [3:0]    b_hi, c_hi, t_hi;
    logic [7:0]    b_lo, c_lo;
    logic          take;
    logic          tmo_hit;
    logic          bad;

    // clr_rdy masks the byte still sitting on rdy while UART_rcv drops it
    assign take    = bus.rdy & ~bus.clr_rdy;
    assign tmo_hit = (state != SYNC1) && (tmo == TMO_M1);

    always_comb begin
        bad = 1'b0;
        if (take) begin
            unique case (state)
                SYNC2:
                    bad = (bus.rx_data != 8'h55) && (bus.rx_data != 8'hAA);
                B_HI, C_HI, T_HI:
                    bad = bus.rx_data[7:4] != 4'h0;
                default:
                    bad = 1'b0;
            endcase
        end else begin
            bad = tmo_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SYNC1;
            tmo         <= '0;
            b_hi        <= '0;
            c_hi        <= '0;
            t_hi        <= '0;
            b_lo        <= '0;
            c_lo        <= '0;
            bus.clr_rdy <= 1'b0;
            bus.vld     <= 1'b0;
            bus.frm_err <= 1'b0;
            bus.batt    <= '0;
            bus.curr    <= '0;
            bus.torque  <= '0;
            bus.pkt_cnt <= '0;
            bus.err_cnt <= '0;
        end else begin
            bus.clr_rdy <= take;
            bus.vld     <= 1'b0;
            bus.frm_err <= bad;

            if (bad && bus.err_cnt != 8'hFF)
                bus.err_cnt <= bus.err_cnt + 8'd1;

            if (take || state == SYNC1 || tmo_hit)
                tmo <= '0;
            else
                tmo <= tmo + CW'(1);

            if (bad) begin
                state <= SYNC1;
            end else if (take) begin
                case (state)
                    SYNC1:
                        if (bus.rx_data == 8'hAA) state <= SYNC2;
                    SYNC2:
                        if (bus.rx_data == 8'h55) state <= B_HI;
                    B_HI: begin
                        b_hi  <= bus.rx_data[3:0];
                        state <= B_LO;
                    end
                    B_LO: begin
                        b_lo  <= bus.rx_data;
                        state <= C_HI;
                    end
                    C_HI: begin
                        c_hi  <= bus.rx_data[3:0];
                        state <= C_LO;
                    end
                    C_LO: begin
                        c_lo  <= bus.rx_data;
                        state <= T_HI;
                    end
                    T_HI: begin
                        t_hi  <= bus.rx_data[3:0];
                        state <= T_LO;
                    end
                    T_LO: begin
                        bus.batt    <= {b_hi, b_lo};
                        bus.curr    <= {c_hi, c_lo};
                        bus.torque  <= {t_hi, bus.rx_data};
                        bus.vld     <= 1'b1;
                        bus.pkt_cnt <= bus.pkt_cnt + 8'd1;
                        state       <= SYNC1;
                    end
                    default:
                        state <= SYNC1;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_telem_rx.sv
// Bench for telem_rx: fixed vectors, stall/reset corner sequences and
// random byte streams against a packet-level reference model.
module tb_telem_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    telem_rx_if bus ();

    telem_rx #(.TMO_CYC(200)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: bytes of the packet collected so far
    logic [7:0]  mq[$];
    logic [11:0] mb, mc, mt;
    int          mpkt, merr;
    bit          ev_vld, ev_err;
    int          tot_vld = 0, tot_err = 0;

    task automatic model_fail();
        mq.delete();
        ev_err = 1'b1;
        merr = (merr < 255) ? merr + 1 : 255;
        tot_err++;
    endtask

    task automatic model_byte(input logic [7:0] b);
        ev_vld = 1'b0;
        ev_err = 1'b0;
        case (mq.size())
            0: if (b == 8'hAA) mq.push_back(b);
            1: begin
                if (b == 8'h55) mq.push_back(b);
                else if (b != 8'hAA) model_fail();
            end
            2, 4, 6: begin
                if (b[7:4] != 4'h0) model_fail();
                else mq.push_back(b);
            end
            3, 5: mq.push_back(b);
            default: begin
                mb = {mq[2][3:0], mq[3]};
                mc = {mq[4][3:0], mq[5]};
                mt = {mq[6][3:0], b};
                ev_vld = 1'b1;
                mpkt++;
                tot_vld++;
                mq.delete();
            end
        endcase
    endtask

    task automatic model_reset();
        mq.delete();
        mb = '0; mc = '0; mt = '0;
        mpkt = 0; merr = 0;
    endtask

    // Pulse monitor
    int mon_vld = 0, mon_err = 0;
    bit both_seen = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.vld) mon_vld++;
            if (bus.frm_err) mon_err++;
            if (bus.vld && bus.frm_err) both_seen = 1'b1;
        end
    end

    task automatic send(input logic [7:0] b, input int hold, input int gap);
        repeat (gap) @(negedge clk);
        bus.rdy = 1'b1;
        bus.rx_data = b;
        @(posedge clk);
        @(negedge clk);
        model_byte(b);
        chk("clr_rdy", 64'(bus.clr_rdy), 64'd1);
        chk("vld", 64'(bus.vld), 64'(ev_vld));
        chk("frm_err", 64'(bus.frm_err), 64'(ev_err));
        chk("data", 64'({bus.batt, bus.curr, bus.torque}), 64'({mb, mc, mt}));
        chk("cnts", 64'({bus.pkt_cnt, bus.err_cnt}),
            64'({mpkt[7:0], merr[7:0]}));
        if (hold > 1) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.rdy = 1'b0;
        bus.rx_data = 8'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pulses", 64'({bus.clr_rdy, bus.vld, bus.frm_err}), 64'd0);
        chk("rst_data", 64'({bus.batt, bus.curr, bus.torque}), 64'd0);
        chk("rst_cnts", 64'({bus.pkt_cnt, bus.err_cnt}), 64'd0);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [0:11][7:0] by;
        int               n;
        logic [11:0]      eb, ec, et;
        logic [7:0]       ep, ee;
    } vec_t;

    vec_t        tab[6];
    logic [7:0]  p[8];
    logic [35:0] v;
    int          kind, hit;

    task automatic build_pkt();
        v = {4'($urandom), 32'($urandom)};
        p[0] = 8'hAA;
        p[1] = 8'h55;
        p[2] = {4'h0, v[35:32]};
        p[3] = v[31:24];
        p[4] = {4'h0, v[23:20]};
        p[5] = v[19:12];
        p[6] = {4'h0, v[11:8]};
        p[7] = v[7:0];
    endtask

    initial begin
        tab[0] = '{by: {8'hAA, 8'h55, 8'h07, 8'h00, 8'h0B, 8'h80, 8'h0F,
                        8'hFF, 32'h0},
                   n: 8, eb: 12'h700, ec: 12'hB80, et: 12'hFFF,
                   ep: 8'd1, ee: 8'd0};
        tab[1] = '{by: {8'h12, 8'h34, 8'hAA, 8'hAA, 8'h55, 8'h05, 8'h00,
                        8'h00, 8'h10, 8'h01, 8'h23, 8'h0},
                   n: 11, eb: 12'h500, ec: 12'h010, et: 12'h123,
                   ep: 8'd2, ee: 8'd0};
        tab[2] = '{by: {8'hAA, 8'h55, 8'h17, 72'h0},
                   n: 3, eb: 12'h500, ec: 12'h010, et: 12'h123,
                   ep: 8'd2, ee: 8'd1};
        tab[3] = '{by: {8'hAA, 8'h33, 80'h0},
                   n: 2, eb: 12'h500, ec: 12'h010, et: 12'h123,
                   ep: 8'd2, ee: 8'd2};
        tab[4] = '{by: {8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                        8'h06, 32'h0},
                   n: 8, eb: 12'h102, ec: 12'h304, et: 12'h506,
                   ep: 8'd3, ee: 8'd2};
        tab[5] = '{by: {8'hAA, 8'h55, 8'h00, 8'hFF, 8'h20, 56'h0},
                   n: 5, eb: 12'h102, ec: 12'h304, et: 12'h506,
                   ep: 8'd3, ee: 8'd3};

        bus.rdy = 1'b0;
        bus.rx_data = 8'h00;
        model_reset();
        do_reset();

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < tab[i].n; j++)
                send(tab[i].by[j], 1, 1);
            chk("tab_batt", 64'(bus.batt), 64'(tab[i].eb));
            chk("tab_curr", 64'(bus.curr), 64'(tab[i].ec));
            chk("tab_torque", 64'(bus.torque), 64'(tab[i].et));
            chk("tab_pkt_cnt", 64'(bus.pkt_cnt), 64'(tab[i].ep));
            chk("tab_err_cnt", 64'(bus.err_cnt), 64'(tab[i].ee));
        end

        // Stall after byte 4 until the inter-byte timeout fires
        send(8'hAA, 1, 1);
        send(8'h55, 1, 1);
        send(8'h07, 1, 1);
        send(8'h00, 1, 1);
        send(8'h0B, 1, 1);
        hit = -1;
        for (int k = 1; k <= 260; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.frm_err && hit < 0) hit = k;
        end
        chk("tmo_cycle", 64'(hit), 64'd200);
        mq.delete();
        merr = (merr < 255) ? merr + 1 : 255;
        tot_err++;
        chk("tmo_err_cnt", 64'(bus.err_cnt), 64'd4);
        send(8'h80, 1, 1);
        send(8'h0F, 1, 1);
        send(8'hFF, 1, 1);
        send(8'h12, 1, 1);
        chk("tmo_stray_pkt", 64'(bus.pkt_cnt), 64'd3);

        // Byte accepted on the very edge the timeout would fire
        send(8'hAA, 1, 1);
        send(8'h55, 1, 1);
        send(8'h03, 1, 1);
        send(8'h00, 1, 199);
        send(8'h0B, 1, 1);
        send(8'h80, 1, 1);
        send(8'h0F, 1, 1);
        send(8'hFF, 2, 1);
        chk("edge_batt", 64'(bus.batt), 64'h300);
        chk("edge_err_cnt", 64'(bus.err_cnt), 64'd4);

        for (int i = 0; i < 150; i++) begin
            kind = int'($urandom_range(0, 3));
            build_pkt();
            if (kind == 1) p[$urandom_range(1, 7)] = 8'($urandom);
            if (kind == 3) begin
                send(8'($urandom), int'($urandom_range(1, 2)),
                     int'($urandom_range(1, 3)));
            end else begin
                for (int j = 0; j < 8; j++)
                    send(p[j], int'($urandom_range(1, 2)),
                         int'($urandom_range(1, 3)));
            end
        end

        // Reset in the middle of a packet
        send(8'hAA, 1, 1);
        send(8'h55, 1, 1);
        send(8'h01, 1, 1);
        send(8'h02, 1, 1);
        send(8'h03, 1, 1);
        send(8'h04, 1, 1);
        do_reset();
        send(8'hAA, 1, 1);
        send(8'h55, 1, 1);
        send(8'h0A, 1, 1);
        send(8'hBC, 1, 1);
        send(8'h0D, 1, 1);
        send(8'hEF, 1, 1);
        send(8'h01, 1, 1);
        send(8'h23, 1, 1);
        chk("post_rst_vld", 64'(bus.vld), 64'd1);
        chk("post_rst_pkt", 64'(bus.pkt_cnt), 64'd1);
        chk("post_rst_data", 64'({bus.batt, bus.curr, bus.torque}),
            64'h ABC_DEF_123);

        do_reset();
        for (int i = 0; i < 256; i++) begin
            build_pkt();
            for (int j = 0; j < 8; j++) send(p[j], 1, 1);
        end
        chk("pkt_wrap", 64'(bus.pkt_cnt), 64'd0);
        for (int i = 0; i < 260; i++) begin
            send(8'hAA, 1, 1);
            send(8'h33, 1, 1);
        end
        chk("err_sat", 64'(bus.err_cnt), 64'd255);

        repeat (3) @(negedge clk);
        chk("mon_vld_total", 64'(mon_vld), 64'(tot_vld));
        chk("mon_err_total", 64'(mon_err), 64'(tot_err));
        chk("vld_err_overlap", 64'(both_seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/telem_rx.md
# telem_rx

Telemetry packet receiver for the eBike testbench, directly downstream of `UART_rcv`. It consumes the byte stream the DUT transmits on `TX`, one `rdy`/`rx_data` byte at a time, and frames 8-byte telemetry packets. It reassembles the 12-bit battery, current and torque values and presents them as one atomic, validated triple for the self-checking bench. Framing faults and mid-packet stalls are detected and counted.

## Interface
Parameters:
- `TMO_CYC`, default 100000: maximum clk cycles allowed between consecutive bytes inside a packet before the packet is abandoned.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rdy` in 1: byte available from `UART_rcv`.
- `rx_data` in 8: received byte, valid while `rdy`=1.
- `clr_rdy` out 1: registered; consumes the byte; drives `UART_rcv.clr_rdy`.
- `batt` out 12: last good battery value.
- `curr` out 12: last good current value.
- `torque` out 12: last good torque value.
- `vld` out 1: one-cycle pulse; `batt`, `curr` and `torque` were just updated together.
- `frm_err` out 1: one-cycle pulse; a packet was discarded.
- `pkt_cnt` out 8: good-packet count, wraps from 255 to 0.
- `err_cnt` out 8: discarded-packet count, saturates at 255.

## Operation
- Packet format, in order:
  - byte 0: 0xAA
  - byte 1: 0x55
  - byte 2: {4'h0, batt[11:8]}
  - byte 3: batt[7:0]
  - byte 4: {4'h0, curr[11:8]}
  - byte 5: curr[7:0]
  - byte 6: {4'h0, torque[11:8]}
  - byte 7: torque[7:0]
- Byte accept condition: on a clk edge where `rdy`=1 and `clr_rdy`=0.
  - On accept, `clr_rdy` is set to 1 for exactly the next cycle.
  - The `clr_rdy`=0 term stops a byte from being consumed twice while `rdy` is still falling.
- FSM states: SYNC1, SYNC2, B_HI, B_LO, C_HI, C_LO, T_HI, T_LO. Reset state is SYNC1. Transitions happen only on an accepted byte, except for the timeout.
  - SYNC1: 0xAA goes to SYNC2. Any other byte is dropped silently (hunting for sync, no error).
  - SYNC2: 0x55 goes to B_HI. 0xAA stays in SYNC2 (treated as a new first delimiter). Any other byte goes to SYNC1 and raises the error action.
  - B_HI, C_HI, T_HI: if upper nibble ≠ 0, go to SYNC1 and raise the error action. Otherwise store the nibble in the shadow register and advance.
  - B_LO, C_LO: store the byte in the shadow register and advance.
  - T_LO: copy the shadows and this byte into `batt`, `curr` and `torque` on the same edge, pulse `vld`, increment `pkt_cnt`, go to SYNC1.
- Error action: pulse `frm_err`, increment `err_cnt` (saturating), leave `batt`, `curr` and `torque` unchanged.
- Timeout: an inter-byte counter runs in every state except SYNC1.
  - It clears on every accepted byte.
  - When it reaches `TMO_CYC`-1, the FSM goes to SYNC1 and raises the error action.
  - Counter width is `$clog2(TMO_CYC)`+1.
- Outputs never show a partially updated packet. Shadow registers are internal.

## Timing
- Reset values: state SYNC1; `clr_rdy`, `vld` and `frm_err` are 0; `batt`, `curr`, `torque`, `pkt_cnt`, `err_cnt` and the shadows are 0; timeout counter 0.
- Every output is registered. No combinational path from input to output.
- Latency: `vld` and the new data appear 1 cycle after the edge that accepts byte 7. `frm_err` appears 1 cycle after the offending edge, or after the timeout edge.
- `vld` and `frm_err` are never high in the same cycle.
- If a timeout and a byte accept land on the same edge, the accept wins and the counter clears.
- `rdy` held high across several cycles yields exactly one accept per `clr_rdy` handshake.
- Asserting `rst_n` mid-packet aborts immediately. No `frm_err` is raised and the counters are zeroed.

## Test plan
- Good packet AA 55 07 00 0B 80 0F FF → one `vld` pulse; `batt`=0x700, `curr`=0xB80, `torque`=0xFFF; `pkt_cnt`=1; `frm_err` never asserts.
- Leading garbage 12 34 AA AA 55 05 00 00 10 01 23 → `vld` with `batt`=0x500, `curr`=0x010, `torque`=0x123; `err_cnt`=0.
- Bad high nibble AA 55 17 … → `frm_err` pulse after byte 2; `err_cnt`=1; outputs keep their previous values; next good packet is still accepted.
- Stall after byte 4 longer than `TMO_CYC` (set 200) → `frm_err` pulse at cycle 200 after the last accept; FSM returns to SYNC1; the next 4 stray bytes produce no `vld`.
- 256 good packets then 260 bad packets → `pkt_cnt` wraps to 0; `err_cnt` saturates at 255.
- Assert `rst_n` low after byte 5 → all outputs at reset values; a full packet afterwards gives `vld` and `pkt_cnt`=1.
